// File: rtl/mod12_wrap_tracker_if.sv
// Bus between the mod-12 counter/consumer side and the wrap tracker:
// counter snoop inputs, clear, wrap pulses/count and the event-record stream.
interface mod12_wrap_tracker_if #(
  parameter int WRAP_W = 8
);
  logic [3:0]        cnt_in;
  logic              cnt_load;
  logic              cnt_mode;
  logic              clr;
  logic              up_wrap;
  logic              dn_wrap;
  logic [WRAP_W-1:0] wrap_cnt;
  // Record stream: a transfer happens on a cycle where ev_valid & ev_ready are
  // both high; while ev_valid is high and ev_ready low, ev_valid/ev_data hold.
  logic              ev_valid;
  logic              ev_ready;
  logic [WRAP_W:0]   ev_data;
  logic              ovf;

  modport master (
    output cnt_in, cnt_load, cnt_mode, clr, ev_ready,
    input  up_wrap, dn_wrap, wrap_cnt, ev_valid, ev_data, ovf
  );

  modport slave (
    input  cnt_in, cnt_load, cnt_mode, clr, ev_ready,
    output up_wrap, dn_wrap, wrap_cnt, ev_valid, ev_data, ovf
  );
endinterface

// File: rtl/mod12_wrap_tracker.sv
// Detects 11->0 (up) and 0->11 (down) wraps of a mod-12 counter, keeps a net
// wrap count and queues one {dir, count} record per wrap in a FWFT FIFO.
module mod12_wrap_tracker #(
  parameter int WRAP_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  mod12_wrap_tracker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]        prev_val_q;
  logic              prev_load_q;
  logic              prev_mode_q;
  logic              prev_vld_q;
  logic              up_q;
  logic              dn_q;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [WRAP_W:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic up_det, dn_det, push, pop, full, push_ok;

  always_comb begin
    // A loaded value never counts as a wrap, and clr masks detection outright.
    up_det = prev_vld_q & ~prev_load_q & ~prev_mode_q & (prev_val_q == 4'd11)
           & (bus.cnt_in == 4'd0) & ~bus.clr;
    dn_det = prev_vld_q & ~prev_load_q & prev_mode_q & (prev_val_q == 4'd0)
           & (bus.cnt_in == 4'd11) & ~bus.clr;

    wrap_cnt_d = wrap_cnt_q;
    if (up_det)      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    else if (dn_det) wrap_cnt_d = wrap_cnt_q - WRAP_W'(1);

    pop     = (count_q != '0) & bus.ev_ready;
    full    = (count_q == CW'(DEPTH));
    push    = up_det | dn_det;
    // A full FIFO still accepts when its head leaves in the same cycle.
    push_ok = push & (~full | pop);

    count_d = count_q;
    if (push_ok & ~pop)      count_d = count_q + CW'(1);
    else if (pop & ~push_ok) count_d = count_q - CW'(1);

    ovf_d = ovf_q | (push & ~push_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_val_q  <= '0;
      prev_load_q <= 1'b0;
      prev_mode_q <= 1'b0;
      prev_vld_q  <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      wrap_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.clr) begin
      prev_val_q  <= bus.cnt_in;
      prev_load_q <= bus.cnt_load;
      prev_mode_q <= bus.cnt_mode;
      prev_vld_q  <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      wrap_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      prev_val_q  <= bus.cnt_in;
      prev_load_q <= bus.cnt_load;
      prev_mode_q <= bus.cnt_mode;
      prev_vld_q  <= 1'b1;
      up_q        <= up_det;
      dn_q        <= dn_det;
      wrap_cnt_q  <= wrap_cnt_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {dn_det, wrap_cnt_d};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign bus.up_wrap  = up_q;
  assign bus.dn_wrap  = dn_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.ev_valid = (count_q != '0);
  assign bus.ev_data  = mem_q[rd_ptr_q];
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_mod12_wrap_tracker.sv
// Directed plus randomized bench for mod12_wrap_tracker against a queue-based
// model of wraps, net count, record FIFO and overflow.
module tb_mod12_wrap_tracker;
  localparam int WRAP_W = 8;
  localparam int DEPTH  = 4;
  localparam int MOD    = 1 << WRAP_W;

  logic clk;
  logic rst;

  mod12_wrap_tracker_if #(.WRAP_W(WRAP_W)) bus ();

  mod12_wrap_tracker #(.WRAP_W(WRAP_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [WRAP_W:0] exp_q[$];
  int   m_cnt;
  bit   m_up, m_dn, m_ovf, m_vld, m_pload, m_pmode;
  int   m_pval;
  int   errors;
  int   checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle, advances the model, then checks every output after the edge.
  task automatic cycle(input int v, input bit ld, input bit md, input bit cl,
                       input bit rdy, input bit rs);
    bit du, dd, pop;
    rst          = rs;
    bus.cnt_in   = 4'(v);
    bus.cnt_load = ld;
    bus.cnt_mode = md;
    bus.clr      = cl;
    bus.ev_ready = rdy;
    if (rs || cl) begin
      m_cnt = 0; exp_q.delete(); m_ovf = 0; m_vld = 0; m_up = 0; m_dn = 0;
    end else begin
      du  = m_vld && !m_pload && !m_pmode && m_pval == 11 && v == 0;
      dd  = m_vld && !m_pload &&  m_pmode && m_pval == 0  && v == 11;
      pop = (exp_q.size() != 0) && rdy;
      if (du) m_cnt = (m_cnt + 1) % MOD;
      if (dd) m_cnt = (m_cnt + MOD - 1) % MOD;
      if (pop) void'(exp_q.pop_front());
      if (du || dd) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({dd, WRAP_W'(m_cnt)});
        else m_ovf = 1;
      end
      m_up = du; m_dn = dd; m_vld = 1;
    end
    m_pval = v; m_pload = ld; m_pmode = md;
    @(posedge clk);
    #1;
    chk("up_wrap",  32'(bus.up_wrap),  32'(m_up));
    chk("dn_wrap",  32'(bus.dn_wrap),  32'(m_dn));
    chk("wrap_cnt", 32'(bus.wrap_cnt), 32'(m_cnt));
    chk("ovf",      32'(bus.ovf),      32'(m_ovf));
    chk("ev_valid", 32'(bus.ev_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("ev_data", 32'(bus.ev_data), 32'(exp_q[0]));
  endtask

  task automatic up_wraps(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      cycle(11, 0, 0, 0, rdy, 0);
      cycle(0, 0, 0, 0, rdy, 0);
    end
  endtask

  initial begin
    int  cur, nxt;
    bit  ld, md;
    errors = 0; checks = 0;
    m_cnt = 0; m_up = 0; m_dn = 0; m_ovf = 0; m_vld = 0;
    m_pval = 0; m_pload = 0; m_pmode = 0;
    rst = 1; bus.cnt_in = '0; bus.cnt_load = 0; bus.cnt_mode = 0;
    bus.clr = 0; bus.ev_ready = 0;

    // reset state
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("rst_ev_data", 32'(bus.ev_data), 32'h0);
    chk("rst_wrap_cnt", 32'(bus.wrap_cnt), 32'h0);

    // single up wrap
    cycle(9, 0, 0, 0, 1, 0);
    cycle(10, 0, 0, 0, 1, 0);
    cycle(11, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("up_pulse", 32'(bus.up_wrap), 32'h1);
    chk("up_rec", 32'(bus.ev_data), 32'h001);
    cycle(1, 0, 1, 0, 1, 0);
    chk("up_rec_gone", 32'(bus.ev_valid), 32'h0);

    // down wrap, then a load of 11 from 0 that must not count
    cycle(0, 0, 1, 0, 1, 0);
    cycle(11, 0, 1, 0, 1, 0);
    chk("dn_pulse", 32'(bus.dn_wrap), 32'h1);
    chk("dn_rec", 32'(bus.ev_data), 32'h100);
    cycle(10, 0, 1, 0, 1, 0);
    cycle(0, 1, 1, 0, 1, 0);
    cycle(11, 0, 1, 0, 1, 0);
    chk("load_no_dn", 32'(bus.dn_wrap), 32'h0);

    // backpressure: five wraps into a four-deep FIFO, then drain
    up_wraps(5, 0);
    chk("bp_wrap_cnt", 32'(bus.wrap_cnt), 32'd5);
    chk("bp_ovf", 32'(bus.ovf), 32'h1);
    for (int i = 0; i < 6; i++) cycle(5, 1, 0, 0, 1, 0);

    // push into a full FIFO with a simultaneous pop
    cycle(5, 0, 0, 1, 0, 0);
    up_wraps(4, 0);
    cycle(11, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("fullpop_ovf", 32'(bus.ovf), 32'h0);
    for (int i = 0; i < 6; i++) cycle(5, 1, 0, 0, 1, 0);

    // net count wrap-around in both directions
    cycle(5, 0, 0, 1, 1, 0);
    up_wraps(255, 1);
    chk("cnt_255", 32'(bus.wrap_cnt), 32'd255);
    up_wraps(1, 1);
    chk("cnt_wrap0", 32'(bus.wrap_cnt), 32'd0);
    cycle(0, 0, 1, 0, 1, 0);
    cycle(11, 0, 1, 0, 1, 0);
    chk("cnt_wrap255", 32'(bus.wrap_cnt), 32'd255);

    // clr, then rst, with three records queued and ovf set
    for (int pass = 0; pass < 2; pass++) begin
      cycle(5, 0, 0, 1, 0, 0);
      up_wraps(5, 0);
      cycle(5, 1, 0, 0, 1, 0);
      cycle(11, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, pass == 0, 0, pass == 1);
      chk("flush_valid", 32'(bus.ev_valid), 32'h0);
      chk("flush_ovf", 32'(bus.ovf), 32'h0);
      cycle(11, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      chk("flush_det_ok", 32'(bus.up_wrap), 32'h1);
    end

    // randomized counter-like traffic
    cur = 0; md = 0;
    for (int i = 0; i < 2500; i++) begin
      ld = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) md = ~md;
      cycle(cur, ld, md, $urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 299) == 0);
      if (ld)      nxt = $urandom_range(0, 11);
      else if (md) nxt = (cur == 0) ? 11 : cur - 1;
      else         nxt = (cur == 11) ? 0 : cur + 1;
      cur = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
